// File: rtl/uart_tx_fifo_reader.sv
// UART 8N1 transmitter draining a show-ahead FIFO, one pop per frame.
// Define UART_TX_PARITY_EN to insert an even-parity bit before stop.
module uart_tx_fifo_reader #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_fifo_not_empty,
  input  logic [7:0] i_fifo_rd_data,
  output logic       o_fifo_rd_en,
  output logic       o_tx_serial,
  output logic       o_tx_active,
  output logic       o_tx_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          line_q, line_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          rd_en;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign bit_end = (cnt_q == CNT_LAST);

  // Next state, counters and the registered line/status values
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    rd_en    = 1'b0;
    line_d   = 1'b1;
    active_d = 1'b1;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_fifo_not_empty) begin
          rd_en   = 1'b1;
          shift_d = i_fifo_rd_data;
`ifdef UART_TX_PARITY_EN
          par_d   = ^i_fifo_rd_data;
`endif
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    case (state_d)
      IDLE:   active_d = 1'b0;
      START:  line_d   = 1'b0;
      DATA:   line_d   = shift_d[bit_d];
`ifdef UART_TX_PARITY_EN
      PARITY: line_d   = par_d;
`endif
      default: line_d  = 1'b1;
    endcase
    done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
  end

  // State and datapath registers; reset forces the line idle at once
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      line_q   <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      line_q   <= line_d;
      active_q <= active_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign o_fifo_rd_en = rd_en;
  assign o_tx_serial  = line_q;
  assign o_tx_active  = active_q;
  assign o_tx_done    = done_q;

endmodule
